block_table: RTL and testbench



---
 rtl/block_table_pkg.sv | 16 +
 rtl/block_slot.sv | 116 +++++++++++
 rtl/bram_1_1.sv | 29 ++
 rtl/mux_generic.sv | 17 +
 rtl/block_table.sv | 146 ++++++++++++++
 tb/tb_block_table.sv | 259 +++++++++++++++++++++++++
 6 files changed

// File: rtl/block_table_pkg.sv
// Shared types and constants for the per-MP resident block table.
package block_table_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } slot_state_e;

   // Special-register selectors carried in src1[1:0] when src1's upper bits are all ones
   localparam logic [1:0] SPEC_BIDX  = 2'b11;
   localparam logic [1:0] SPEC_BDIM  = 2'b10;
   localparam logic [1:0] SPEC_GDIM  = 2'b01;
   localparam logic [1:0] SPEC_PARAM = 2'b00;

endpackage

// File: rtl/block_slot.sv
// One resident block slot: lifecycle FSM, live-warp and barrier counters,
// and the launch fields captured at handshake.
module block_slot
   import block_table_pkg::*;
#(
   parameter int WARPID_DEPTH = 4,
   parameter int BLOCK_DIM    = 32,
   parameter int GRID_DIM     = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    launch,
   input  logic [WARPID_DEPTH:0]   num_warp,
   input  logic [BLOCK_DIM-1:0]    launch_bdim,
   input  logic [GRID_DIM-1:0]     launch_gdim,
   input  logic [GRID_DIM-1:0]     launch_bidx,
   input  logic                    ev,
   input  logic                    bar,
   input  logic                    wexit,
   output logic                    free,
   output logic                    active,
   output logic                    bar_release,
   output logic                    done,
   output logic [BLOCK_DIM-1:0]    bdim,
   output logic [GRID_DIM-1:0]     gdim,
   output logic [GRID_DIM-1:0]     bidx
);

   slot_state_e             state_q;
   slot_state_e             state_d;
   logic [WARPID_DEPTH:0]   live;
   logic [WARPID_DEPTH:0]   bar_cnt;
   logic [WARPID_DEPTH:0]   live_nxt;
   logic [WARPID_DEPTH:0]   bar_nxt;
   logic                    is_exit;
   logic                    is_bar;
   logic                    release_hit;
   logic                    done_set;
   logic                    take_launch;

   // Event decode and counter look-ahead; wexit wins over bar
   always_comb begin
      is_exit     = ev & wexit & (state_q == ACTIVE);
      is_bar      = ev & bar & ~wexit & (state_q == ACTIVE);
      bar_nxt     = bar_cnt + (WARPID_DEPTH+1)'(is_bar);
      live_nxt    = live - (WARPID_DEPTH+1)'(is_exit);
      release_hit = (is_bar | is_exit) && (bar_nxt == live_nxt) && (live_nxt != '0);
      take_launch = launch & (state_q == FREE);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= FREE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         FREE:    if (take_launch) state_d = ACTIVE;
         ACTIVE:  if (is_exit && (live_nxt == '0)) state_d = DRAIN;
         DRAIN:   state_d = FREE;
         default: state_d = FREE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      free     = (state_q == FREE);
      active   = (state_q == ACTIVE);
      done_set = (state_q == DRAIN);
   end

   // Live and barrier counters; a release clears the barrier count
   always_ff @(posedge clk) begin
      if (!rst) begin
         live    <= '0;
         bar_cnt <= '0;
      end else if (take_launch) begin
         live    <= num_warp;
         bar_cnt <= '0;
      end else begin
         live    <= live_nxt;
         bar_cnt <= release_hit ? '0 : bar_nxt;
      end
   end

   // Launch fields captured on the handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         bdim <= '0;
         gdim <= '0;
         bidx <= '0;
      end else if (take_launch) begin
         bdim <= launch_bdim;
         gdim <= launch_gdim;
         bidx <= launch_bidx;
      end
   end

   // One-cycle release and completion pulses
   always_ff @(posedge clk) begin
      if (!rst) begin
         bar_release <= 1'b0;
         done        <= 1'b0;
      end else begin
         bar_release <= release_hit;
         done        <= done_set;
      end
   end

endmodule

// File: rtl/bram_1_1.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// A same-cycle read and write to one address returns the old contents.
module bram_1_1 #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port and registered read port share one clock
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/mux_generic.sv
// N-to-1 multiplexer over a flat bus of N words.
module mux_generic #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N*WIDTH-1:0] in,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out
);

   // Word select by index
   always_comb begin
      out = in[sel*WIDTH +: WIDTH];
   end

endmodule

// File: rtl/block_table.sv
// Per-MP table of resident thread-block contexts: launch handshake,
// special-register reads, barrier release and block completion.
module block_table
   import block_table_pkg::*;
#(
   parameter int NUM_BLOCKS    = 4,
   parameter int BLOCKID_DEPTH = $clog2(NUM_BLOCKS),
   parameter int NUM_WARPS     = 16,
   parameter int WARPID_DEPTH  = $clog2(NUM_WARPS),
   parameter int BLOCK_DIM     = 32,
   parameter int GRID_DIM      = 32,
   parameter int R_DATA_WIDTH  = 32,
   parameter int SRC_WIDTH     = 5,
   parameter int NUM_PARAMS    = 8,
   parameter int PARAM_DEPTH   = $clog2(NUM_PARAMS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     init_valid,
   output logic                     init_ready,
   input  logic [BLOCKID_DEPTH-1:0] init_bid,
   input  logic [WARPID_DEPTH:0]    init_num_warp,
   input  logic [BLOCK_DIM-1:0]     init_bdim,
   input  logic [GRID_DIM-1:0]      init_gdim,
   input  logic [GRID_DIM-1:0]      init_bidx,
   input  logic                     pwe,
   input  logic [BLOCKID_DEPTH-1:0] pbid,
   input  logic [PARAM_DEPTH-1:0]   pwa,
   input  logic [R_DATA_WIDTH-1:0]  param,
   input  logic                     rd_en,
   input  logic [BLOCKID_DEPTH-1:0] bid,
   input  logic [SRC_WIDTH-1:0]     src1,
   input  logic                     wup,
   input  logic                     bar,
   input  logic                     wexit,
   output logic [R_DATA_WIDTH-1:0]  spec_o,
   output logic                     spec_vld_o,
   output logic [NUM_BLOCKS-1:0]    bar_release_o,
   output logic [NUM_BLOCKS-1:0]    done_o,
   output logic [NUM_BLOCKS-1:0]    valid_o
);

   localparam int FW = 3 * R_DATA_WIDTH;

   logic [NUM_BLOCKS-1:0]    slot_free;
   logic [NUM_BLOCKS*FW-1:0] slot_fields;
   logic [FW-1:0]            cur_fields;
   logic [R_DATA_WIDTH-1:0]  field_val;
   logic [R_DATA_WIDTH-1:0]  field_q;
   logic [R_DATA_WIDTH-1:0]  param_rd;
   logic                     use_param_q;
   logic [1:0]               sel;

   assign init_ready = slot_free[init_bid];

   for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_slot
      logic [BLOCK_DIM-1:0] s_bdim;
      logic [GRID_DIM-1:0]  s_gdim;
      logic [GRID_DIM-1:0]  s_bidx;

      block_slot #(
         .WARPID_DEPTH (WARPID_DEPTH),
         .BLOCK_DIM    (BLOCK_DIM),
         .GRID_DIM     (GRID_DIM)
      ) u_slot (
         .clk         (clk),
         .rst         (rst),
         .launch      (init_valid && (init_bid == BLOCKID_DEPTH'(gi))),
         .num_warp    (init_num_warp),
         .launch_bdim (init_bdim),
         .launch_gdim (init_gdim),
         .launch_bidx (init_bidx),
         .ev          (wup && (bid == BLOCKID_DEPTH'(gi))),
         .bar         (bar),
         .wexit       (wexit),
         .free        (slot_free[gi]),
         .active      (valid_o[gi]),
         .bar_release (bar_release_o[gi]),
         .done        (done_o[gi]),
         .bdim        (s_bdim),
         .gdim        (s_gdim),
         .bidx        (s_bidx)
      );

      assign slot_fields[gi*FW +: FW] =
         {R_DATA_WIDTH'(s_bidx), R_DATA_WIDTH'(s_bdim), R_DATA_WIDTH'(s_gdim)};
   end

   // Parameter banks share one RAM addressed {slot, index}
   bram_1_1 #(
      .DATA_WIDTH (R_DATA_WIDTH),
      .ADDR_WIDTH (BLOCKID_DEPTH + PARAM_DEPTH),
      .DEPTH      (NUM_BLOCKS * NUM_PARAMS)
   ) u_params (
      .clk   (clk),
      .we    (pwe),
      .waddr ({pbid, pwa}),
      .wdata (param),
      .re    (rd_en),
      .raddr ({bid, src1[PARAM_DEPTH-1:0]}),
      .rdata (param_rd)
   );

   // Special selector: only when the upper src1 bits are all ones
   always_comb begin
      sel = (&src1[SRC_WIDTH-1:2]) ? src1[1:0] : SPEC_PARAM;
   end

   mux_generic #(
      .WIDTH (FW),
      .N     (NUM_BLOCKS)
   ) u_slot_mux (
      .in  (slot_fields),
      .sel (bid),
      .out (cur_fields)
   );

   // Word 0 is tied to zero; the parameter path bypasses this mux
   mux_generic #(
      .WIDTH (R_DATA_WIDTH),
      .N     (4)
   ) u_field_mux (
      .in  ({cur_fields, {R_DATA_WIDTH{1'b0}}}),
      .sel (sel),
      .out (field_val)
   );

   // Field value is registered alongside the RAM read so both land together;
   // reset selects the cleared field register so spec_o reads zero
   always_ff @(posedge clk) begin
      if (!rst) begin
         field_q     <= '0;
         use_param_q <= 1'b0;
         spec_vld_o  <= 1'b0;
      end else begin
         spec_vld_o <= rd_en;
         if (rd_en) begin
            field_q     <= field_val;
            use_param_q <= (sel == SPEC_PARAM);
         end
      end
   end

   assign spec_o = use_param_q ? param_rd : field_q;

endmodule

// File: tb/tb_block_table.sv
// Directed self-checking bench for block_table.
module tb_block_table;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_valid;
   logic        init_ready;
   logic [1:0]  init_bid;
   logic [4:0]  init_num_warp;
   logic [31:0] init_bdim;
   logic [31:0] init_gdim;
   logic [31:0] init_bidx;
   logic        pwe;
   logic [1:0]  pbid;
   logic [2:0]  pwa;
   logic [31:0] param;
   logic        rd_en;
   logic [1:0]  bid;
   logic [4:0]  src1;
   logic        wup;
   logic        bar;
   logic        wexit;
   logic [31:0] spec_o;
   logic        spec_vld_o;
   logic [3:0]  bar_release_o;
   logic [3:0]  done_o;
   logic [3:0]  valid_o;

   int tests = 0;
   int fails = 0;

   block_table dut (
      .clk           (clk),
      .rst           (rst),
      .init_valid    (init_valid),
      .init_ready    (init_ready),
      .init_bid      (init_bid),
      .init_num_warp (init_num_warp),
      .init_bdim     (init_bdim),
      .init_gdim     (init_gdim),
      .init_bidx     (init_bidx),
      .pwe           (pwe),
      .pbid          (pbid),
      .pwa           (pwa),
      .param         (param),
      .rd_en         (rd_en),
      .bid           (bid),
      .src1          (src1),
      .wup           (wup),
      .bar           (bar),
      .wexit         (wexit),
      .spec_o        (spec_o),
      .spec_vld_o    (spec_vld_o),
      .bar_release_o (bar_release_o),
      .done_o        (done_o),
      .valid_o       (valid_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      tests++; if (valid_o !== 4'b0000) begin fails++; $display("FAIL reset_valid got %b exp %b", valid_o, 4'b0000); end
      tests++; if (bar_release_o !== 4'b0000) begin fails++; $display("FAIL reset_rel got %b exp %b", bar_release_o, 4'b0000); end
      tests++; if (done_o !== 4'b0000) begin fails++; $display("FAIL reset_done got %b exp %b", done_o, 4'b0000); end
      tests++; if (spec_vld_o !== 1'b0) begin fails++; $display("FAIL reset_vld got %b exp 0", spec_vld_o); end
      tests++; if (spec_o !== 32'h0) begin fails++; $display("FAIL reset_spec got %h exp 0", spec_o); end
      init_bid = 2'd2;
      #1;
      tests++; if (init_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", init_ready); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_launch();
      init_bid = 2'd2; init_num_warp = 5'd4;
      init_bdim = 32'h0020_0010; init_gdim = 32'h0000_0008; init_bidx = 32'h0000_0003;
      init_valid = 1'b1;
      #1;
      tests++; if (init_ready !== 1'b1) begin fails++; $display("FAIL launch_ready got %b exp 1", init_ready); end
      tick();
      init_valid = 1'b0;
      tests++; if (valid_o !== 4'b0100) begin fails++; $display("FAIL launch_valid got %b exp %b", valid_o, 4'b0100); end
      #1;
      tests++; if (init_ready !== 1'b0) begin fails++; $display("FAIL launch_busy got %b exp 0", init_ready); end
   endtask

   task automatic test_spec_read();
      rd_en = 1'b1; bid = 2'd2; src1 = 5'b11110;
      tick();
      tests++; if (spec_o !== 32'h0020_0010) begin fails++; $display("FAIL rd_bdim got %h exp %h", spec_o, 32'h0020_0010); end
      tests++; if (spec_vld_o !== 1'b1) begin fails++; $display("FAIL rd_vld got %b exp 1", spec_vld_o); end
      src1 = 5'b11111;
      tick();
      tests++; if (spec_o !== 32'h3) begin fails++; $display("FAIL rd_bidx got %h exp 3", spec_o); end
      src1 = 5'b11101;
      tick();
      tests++; if (spec_o !== 32'h8) begin fails++; $display("FAIL rd_gdim got %h exp 8", spec_o); end
      rd_en = 1'b0;
      tick();
      tests++; if (spec_vld_o !== 1'b0) begin fails++; $display("FAIL rd_vld_off got %b exp 0", spec_vld_o); end
   endtask

   task automatic test_barrier();
      logic [3:0] exp;
      bid = 2'd2; wup = 1'b1; bar = 1'b1; wexit = 1'b0;
      // arrivals 1..8: release after 4th and 8th only
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp = ((i == 4) || (i == 8)) ? 4'b0100 : 4'b0000;
         tests++; if (bar_release_o !== exp) begin fails++; $display("FAIL bar_arr%0d got %b exp %b", i, bar_release_o, exp); end
      end
      wup = 1'b0; bar = 1'b0;
      tick();
      tests++; if (bar_release_o !== 4'b0000) begin fails++; $display("FAIL bar_idle got %b exp 0000", bar_release_o); end
   endtask

   task automatic test_exit_release();
      bid = 2'd2; wup = 1'b1; bar = 1'b1; wexit = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         tests++; if (bar_release_o !== 4'b0000) begin fails++; $display("FAIL xr_arr%0d got %b exp 0000", i, bar_release_o); end
      end
      bar = 1'b0; wexit = 1'b1;
      tick();
      tests++; if (bar_release_o !== 4'b0100) begin fails++; $display("FAIL xr_exit got %b exp 0100", bar_release_o); end
      // bar+wexit together counts as exit only: live 3->2, bar_cnt stays 0
      bar = 1'b1; wexit = 1'b1;
      tick();
      tests++; if (bar_release_o !== 4'b0000) begin fails++; $display("FAIL both got %b exp 0000", bar_release_o); end
      wexit = 1'b0;
      tick();
      tests++; if (bar_release_o !== 4'b0000) begin fails++; $display("FAIL both_arr1 got %b exp 0000", bar_release_o); end
      tick();
      tests++; if (bar_release_o !== 4'b0100) begin fails++; $display("FAIL both_arr2 got %b exp 0100", bar_release_o); end
      wup = 1'b0; bar = 1'b0;
   endtask

   task automatic test_drain_relaunch();
      bid = 2'd2; wup = 1'b1; wexit = 1'b1; bar = 1'b0;
      tick();
      tests++; if (valid_o !== 4'b0100) begin fails++; $display("FAIL drain_v1 got %b exp 0100", valid_o); end
      tick();
      wup = 1'b0; wexit = 1'b0;
      tests++; if (valid_o !== 4'b0000) begin fails++; $display("FAIL drain_v0 got %b exp 0000", valid_o); end
      tests++; if (done_o !== 4'b0000) begin fails++; $display("FAIL drain_early got %b exp 0000", done_o); end
      tests++; if (bar_release_o !== 4'b0000) begin fails++; $display("FAIL drain_rel got %b exp 0000", bar_release_o); end
      tick();
      tests++; if (done_o !== 4'b0100) begin fails++; $display("FAIL done_pulse got %b exp 0100", done_o); end
      init_bid = 2'd2;
      #1;
      tests++; if (init_ready !== 1'b1) begin fails++; $display("FAIL done_ready got %b exp 1", init_ready); end
      init_valid = 1'b1; init_num_warp = 5'd2; init_bdim = 32'h0030_0020;
      tick();
      init_valid = 1'b0;
      tests++; if (valid_o !== 4'b0100) begin fails++; $display("FAIL relaunch got %b exp 0100", valid_o); end
      tests++; if (done_o !== 4'b0000) begin fails++; $display("FAIL done_once got %b exp 0000", done_o); end
   endtask

   task automatic test_hold_off();
      init_bid = 2'd2; init_num_warp = 5'd7; init_bdim = 32'h0000_0055; init_valid = 1'b1;
      #1;
      tests++; if (init_ready !== 1'b0) begin fails++; $display("FAIL hold_ready got %b exp 0", init_ready); end
      tick();
      init_valid = 1'b0;
      tests++; if (valid_o !== 4'b0100) begin fails++; $display("FAIL hold_valid got %b exp 0100", valid_o); end
      rd_en = 1'b1; bid = 2'd2; src1 = 5'b11110;
      tick();
      rd_en = 1'b0;
      tests++; if (spec_o !== 32'h0030_0020) begin fails++; $display("FAIL hold_bdim got %h exp %h", spec_o, 32'h0030_0020); end
      // live must still be 2: release on the second arrival
      wup = 1'b1; bar = 1'b1;
      tick();
      tests++; if (bar_release_o !== 4'b0000) begin fails++; $display("FAIL hold_arr1 got %b exp 0000", bar_release_o); end
      tick();
      tests++; if (bar_release_o !== 4'b0100) begin fails++; $display("FAIL hold_arr2 got %b exp 0100", bar_release_o); end
      wup = 1'b0; bar = 1'b0;
   endtask

   task automatic test_free_events();
      bid = 2'd1; wup = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bar = (i < 2); wexit = (i == 2);
         tick();
         tests++; if (bar_release_o !== 4'b0000) begin fails++; $display("FAIL free_rel%0d got %b exp 0000", i, bar_release_o); end
         tests++; if (valid_o !== 4'b0100) begin fails++; $display("FAIL free_valid%0d got %b exp 0100", i, valid_o); end
      end
      wup = 1'b0; bar = 1'b0; wexit = 1'b0;
      tick();
      tests++; if (done_o !== 4'b0000) begin fails++; $display("FAIL free_done got %b exp 0000", done_o); end
   endtask

   task automatic test_params();
      pwe = 1'b1;
      pbid = 2'd0; pwa = 3'd5; param = 32'h1111_1111; tick();
      pbid = 2'd1; pwa = 3'd5; param = 32'hCAFE_F00D; tick();
      pbid = 2'd2; pwa = 3'd4; param = 32'h0BAD_F00D; tick();
      pbid = 2'd2; pwa = 3'd7; param = 32'h0000_0077; tick();
      // same-cycle write and read of bank 1 idx 5 returns the old word
      pbid = 2'd1; pwa = 3'd5; param = 32'hDEAD_BEEF;
      rd_en = 1'b1; bid = 2'd1; src1 = 5'd5;
      tick();
      pwe = 1'b0;
      tests++; if (spec_o !== 32'hCAFE_F00D) begin fails++; $display("FAIL p_bypass got %h exp %h", spec_o, 32'hCAFE_F00D); end
      tick();
      tests++; if (spec_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL p_b1i5 got %h exp %h", spec_o, 32'hDEAD_BEEF); end
      tests++; if (spec_vld_o !== 1'b1) begin fails++; $display("FAIL p_vld got %b exp 1", spec_vld_o); end
      bid = 2'd0;
      tick();
      tests++; if (spec_o !== 32'h1111_1111) begin fails++; $display("FAIL p_b0i5 got %h exp %h", spec_o, 32'h1111_1111); end
      bid = 2'd2; src1 = 5'b11100;
      tick();
      tests++; if (spec_o !== 32'h0BAD_F00D) begin fails++; $display("FAIL p_sel00 got %h exp %h", spec_o, 32'h0BAD_F00D); end
      src1 = 5'b01111;
      tick();
      tests++; if (spec_o !== 32'h0000_0077) begin fails++; $display("FAIL p_notspec got %h exp %h", spec_o, 32'h0000_0077); end
      rd_en = 1'b0;
   endtask

   task automatic test_mid_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tests++; if (valid_o !== 4'b0000) begin fails++; $display("FAIL mrst_valid got %b exp 0000", valid_o); end
      tests++; if (spec_o !== 32'h0) begin fails++; $display("FAIL mrst_spec got %h exp 0", spec_o); end
      tick();
      tests++; if (done_o !== 4'b0000) begin fails++; $display("FAIL mrst_done got %b exp 0000", done_o); end
      init_bid = 2'd2;
      #1;
      tests++; if (init_ready !== 1'b1) begin fails++; $display("FAIL mrst_ready got %b exp 1", init_ready); end
   endtask

   initial begin
      rst = 1'b0; init_valid = 1'b0; init_bid = '0; init_num_warp = '0;
      init_bdim = '0; init_gdim = '0; init_bidx = '0;
      pwe = 1'b0; pbid = '0; pwa = '0; param = '0;
      rd_en = 1'b0; bid = '0; src1 = '0; wup = 1'b0; bar = 1'b0; wexit = 1'b0;
      test_reset();
      test_launch();
      test_spec_read();
      test_barrier();
      test_exit_release();
      test_drain_relaunch();
      test_hold_off();
      test_free_events();
      test_params();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
